memory_stage: RTL and testbench

- Pipeline stage directly upstream of write-back. It registers the execute-to-memory bus and runs loads and stores against a request/grant/response data-memory port.
- Sign- or zero-extends load data and presents the 103-bit memory-to-writeback bus plus a valid to write-back.
- Stalls execute while an access is outstanding and provides forwarding and hazard information.

---
 rtl/memory_stage_pkg.sv | 31 +++
 rtl/memory_stage_mem_align.sv | 52 +++++
 rtl/memory_stage.sv | 168 ++++++++++++++++
 tb/tb_memory_stage.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg
//   Shared definitions for the memory stage: bus widths, the packed layout of
//   the execute-to-memory bus, access size encodings and FSM state encodings.
package memory_stage_pkg;

  localparam int E_TO_M_BUS_WD = 107;
  localparam int M_TO_W_BUS_WD = 103;
  localparam int M_TO_H_BUS_WD = 7;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef struct packed {
    logic        mem_load;
    logic        mem_store;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] store_data;
    logic [31:0] alu_result;
    logic        rf_we;
    logic [4:0]  rf_dest;
    logic [31:0] pc;
  } e_to_m_t;

endpackage

// File: rtl/memory_stage_mem_align.sv
// mem_align
//   Combinational data alignment for the memory stage.
//   Ports:
//     size, is_unsigned, addr_lo   access size, load extension mode, addr[1:0]
//     store_data                   raw store data from execute
//     rdata                        raw read data from memory
//     wstrb, wdata                 store byte enables and lane-replicated data
//     load_ext                     extracted and extended load result
module mem_align
  import memory_stage_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_ext
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    wstrb    = 4'b1111;
    wdata    = store_data;
    load_ext = rdata;
    case (size)
      SIZE_BYTE: begin
        wstrb    = 4'b0001 << addr_lo;
        wdata    = {4{store_data[7:0]}};
        load_ext = is_unsigned ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      end
      SIZE_HALF: begin
        wstrb    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata    = {2{store_data[15:0]}};
        load_ext = is_unsigned ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage
//   Pipeline stage ahead of write-back. Registers the execute-to-memory bus,
//   runs loads/stores over a req/gnt/rvalid data port and hands completed
//   instructions to write-back as single-cycle valid_o pulses.
//   Ports:
//     clk, reset                 clock, async active-high reset
//     previous_valid_i, e_to_m_bus, memory_allowin_o   execute handshake
//     flush_memory               kill the instruction held here
//     valid_o, m_to_w_bus        result to write-back
//     forward_result_memory, m_to_h_bus   forwarding and hazard info
//     data_*                     data memory port
//     mem_timeout_o              sticky overdue-response flag
//
//   state    | meaning
//   ST_IDLE  | no access in flight; request raised combinationally if needed
//   ST_REQ   | request held stable, waiting for data_gnt
//   ST_WAIT  | load granted, waiting for data_rvalid
//   ST_DRAIN | flushed load granted; swallow its data_rvalid
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int RESP_TIMEOUT = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         previous_valid_i,
  input  logic         flush_memory,
  input  logic [106:0] e_to_m_bus,
  output logic         memory_allowin_o,
  output logic         valid_o,
  output logic [102:0] m_to_w_bus,
  output logic [31:0]  forward_result_memory,
  output logic [6:0]   m_to_h_bus,
  output logic         data_req,
  output logic         data_wr,
  output logic [1:0]   data_size,
  output logic [31:0]  data_addr,
  output logic [3:0]   data_wstrb,
  output logic [31:0]  data_wdata,
  input  logic         data_gnt,
  input  logic [31:0]  data_rdata,
  input  logic         data_rvalid,
  output logic         mem_timeout_o
);

  e_to_m_t     bus_q, bus_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic [1:0]  state_q, state_d;
  logic [31:0] load_result_q, load_result_d;
  logic [31:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;

  logic        is_mem, req_active, store_done, load_done, nonmem_done;
  logic [31:0] load_ext, load_result_out;

  mem_align u_align (
    .size        (bus_q.size),
    .is_unsigned (bus_q.is_unsigned),
    .addr_lo     (bus_q.alu_result[1:0]),
    .store_data  (bus_q.store_data),
    .rdata       (data_rdata),
    .wstrb       (data_wstrb),
    .wdata       (data_wdata),
    .load_ext    (load_ext)
  );

  always_comb begin
    is_mem      = bus_q.mem_load | bus_q.mem_store;
    // done_q marks an instruction already handed to write-back that is still
    // sitting in bus_q; it must neither re-request nor pulse valid_o again.
    req_active  = valid_q & is_mem & !done_q &
                  ((state_q == ST_IDLE) | (state_q == ST_REQ));
    store_done  = req_active & !bus_q.mem_load & data_gnt;
    load_done   = (state_q == ST_WAIT) & valid_q & data_rvalid;
    nonmem_done = (state_q == ST_IDLE) & valid_q & !is_mem & !done_q;

    valid_o          = (nonmem_done | store_done | load_done) & !flush_memory;
    memory_allowin_o = (state_q == ST_IDLE) &
                       !(valid_q & is_mem & !(done_q | store_done));

    // Write-back sees the fresh load data in the rvalid cycle itself.
    load_result_out = load_done ? load_ext : load_result_q;

    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_REQ: begin
        if (!req_active)
          state_d = ST_IDLE;
        else if (data_gnt & bus_q.mem_load)
          state_d = flush_memory ? ST_DRAIN : ST_WAIT;
        else if (data_gnt | flush_memory)
          state_d = ST_IDLE;
        else
          state_d = ST_REQ;
      end
      ST_WAIT: begin
        if (data_rvalid)
          state_d = ST_IDLE;
        else if (flush_memory)
          state_d = ST_DRAIN;
      end
      default: begin
        if (data_rvalid)
          state_d = ST_IDLE;
      end
    endcase

    load_result_d = load_result_q;
    if (load_done & !flush_memory)
      load_result_d = load_ext;

    bus_d   = bus_q;
    valid_d = valid_q;
    done_d  = done_q | valid_o;
    if (flush_memory) begin
      bus_d   = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end else if (memory_allowin_o) begin
      bus_d   = e_to_m_bus;
      valid_d = previous_valid_i;
      done_d  = 1'b0;
    end

    // Timeout only raises a flag; the FSM keeps waiting for the response.
    cnt_d     = '0;
    timeout_d = timeout_q;
    if (((state_q == ST_WAIT) | (state_q == ST_DRAIN)) & !data_rvalid) begin
      cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
      if ((RESP_TIMEOUT != 0) && (cnt_d >= 32'(RESP_TIMEOUT)))
        timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_q         <= '0;
      valid_q       <= 1'b0;
      done_q        <= 1'b0;
      state_q       <= ST_IDLE;
      load_result_q <= '0;
      cnt_q         <= '0;
      timeout_q     <= 1'b0;
    end else begin
      bus_q         <= bus_d;
      valid_q       <= valid_d;
      done_q        <= done_d;
      state_q       <= state_d;
      load_result_q <= load_result_d;
      cnt_q         <= cnt_d;
      timeout_q     <= timeout_d;
    end
  end

  assign data_req   = req_active;
  assign data_wr    = bus_q.mem_store;
  assign data_size  = bus_q.size;
  assign data_addr  = bus_q.alu_result;

  assign m_to_w_bus = {bus_q.mem_load, load_result_out, bus_q.alu_result,
                       bus_q.rf_we, bus_q.rf_dest, bus_q.pc};
  assign forward_result_memory = bus_q.mem_load ? load_result_out : bus_q.alu_result;
  assign m_to_h_bus = {valid_q & bus_q.mem_load & !valid_o & !done_q,
                       bus_q.rf_dest, bus_q.rf_we};
  assign mem_timeout_o = timeout_q;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

  logic         clk;
  logic         reset;
  logic         previous_valid_i;
  logic         flush_memory;
  logic [106:0] e_to_m_bus;
  logic         memory_allowin_o;
  logic         valid_o;
  logic [102:0] m_to_w_bus;
  logic [31:0]  forward_result_memory;
  logic [6:0]   m_to_h_bus;
  logic         data_req;
  logic         data_wr;
  logic [1:0]   data_size;
  logic [31:0]  data_addr;
  logic [3:0]   data_wstrb;
  logic [31:0]  data_wdata;
  logic         data_gnt;
  logic [31:0]  data_rdata;
  logic         data_rvalid;
  logic         mem_timeout_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] ld;
    logic        chk_ld;
    logic [4:0]  dest;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  memory_stage #(.RESP_TIMEOUT(8)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .previous_valid_i      (previous_valid_i),
    .flush_memory          (flush_memory),
    .e_to_m_bus            (e_to_m_bus),
    .memory_allowin_o      (memory_allowin_o),
    .valid_o               (valid_o),
    .m_to_w_bus            (m_to_w_bus),
    .forward_result_memory (forward_result_memory),
    .m_to_h_bus            (m_to_h_bus),
    .data_req              (data_req),
    .data_wr               (data_wr),
    .data_size             (data_size),
    .data_addr             (data_addr),
    .data_wstrb            (data_wstrb),
    .data_wdata            (data_wdata),
    .data_gnt              (data_gnt),
    .data_rdata            (data_rdata),
    .data_rvalid           (data_rvalid),
    .mem_timeout_o         (mem_timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every valid_o pulse must match the oldest pushed expectation.
  always @(negedge clk) begin
    #2;
    if (!reset && valid_o) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected valid_o pc=%h", m_to_w_bus[31:0]);
      end else begin
        mon_e = sb_q.pop_front();
        if (m_to_w_bus[69:38] !== mon_e.alu || m_to_w_bus[31:0] !== mon_e.pc ||
            m_to_w_bus[36:32] !== mon_e.dest ||
            (mon_e.chk_ld && m_to_w_bus[101:70] !== mon_e.ld)) begin
          errors++;
          $display("FAIL sb_result got alu=%h ld=%h dest=%0d pc=%h exp alu=%h ld=%h dest=%0d pc=%h",
                   m_to_w_bus[69:38], m_to_w_bus[101:70], m_to_w_bus[36:32], m_to_w_bus[31:0],
                   mon_e.alu, mon_e.ld, mon_e.dest, mon_e.pc);
        end
      end
    end
  end

  function automatic logic [106:0] mk(input logic ld, input logic st, input logic [1:0] sz,
                                      input logic un, input logic [31:0] sd,
                                      input logic [31:0] alu, input logic [4:0] dest,
                                      input logic [31:0] pc);
    return {ld, st, sz, un, sd, alu, 1'b1, dest, pc};
  endfunction

  // Presents one instruction; returns at the negedge after it was captured.
  task automatic issue(input logic [106:0] b);
    int n;
    @(negedge clk);
    e_to_m_bus = b;
    previous_valid_i = 1'b1;
    #1;
    n = 0;
    while (!memory_allowin_o && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!memory_allowin_o) begin
      checks++;
      errors++;
      $display("FAIL issue_allowin got %b need 1 within 20 cycles", memory_allowin_o);
    end
    @(negedge clk);
    previous_valid_i = 1'b0;
    e_to_m_bus = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    previous_valid_i = 1'b0;
    flush_memory = 1'b0;
    e_to_m_bus = '0;
    data_gnt = 1'b0;
    data_rdata = '0;
    data_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (valid_o !== 1'b0 || data_req !== 1'b0 || mem_timeout_o !== 1'b0 ||
        memory_allowin_o !== 1'b1 || m_to_w_bus !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%b req=%b to=%b allow=%b bus=%h need 0 0 0 1 0",
               valid_o, data_req, mem_timeout_o, memory_allowin_o, m_to_w_bus);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_alu();
    sb_q.push_back('{alu: 32'h1234_5678, ld: 32'h0, chk_ld: 1'b0, dest: 5'd5, pc: 32'h0FC});
    issue(mk(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h1234_5678, 5'd5, 32'h0FC));
    #1;
    checks++;
    if (valid_o !== 1'b1 || data_req !== 1'b0 || m_to_w_bus[69:38] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL alu_result got v=%b req=%b alu=%h need 1 0 12345678",
               valid_o, data_req, m_to_w_bus[69:38]);
    end
    checks++;
    if (m_to_h_bus !== {1'b0, 5'd5, 1'b1} || forward_result_memory !== 32'h1234_5678) begin
      errors++;
      $display("FAIL alu_hazard got h=%b fwd=%h need 0001011 12345678",
               m_to_h_bus, forward_result_memory);
    end
    @(negedge clk);
    #1;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL alu_pulse got %b need 0", valid_o);
    end
  endtask

  task automatic test_lb();
    int low;
    sb_q.push_back('{alu: 32'h1003, ld: 32'hFFFF_FF80, chk_ld: 1'b1, dest: 5'd7, pc: 32'h100});
    issue(mk(1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 32'h1003, 5'd7, 32'h100));
    low = 0;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      data_gnt = (i == 2);
      data_rvalid = (i == 3);
      data_rdata = 32'h80AA_BBCC;
      #1;
      if (!memory_allowin_o) low++;
      if (i == 0) begin
        checks++;
        if (data_req !== 1'b1 || data_addr !== 32'h1003 || data_size !== 2'd0 ||
            data_wr !== 1'b0 || m_to_h_bus[6] !== 1'b1) begin
          errors++;
          $display("FAIL lb_request got req=%b addr=%h size=%0d wr=%b pend=%b need 1 1003 0 0 1",
                   data_req, data_addr, data_size, data_wr, m_to_h_bus[6]);
        end
      end
      if (i == 3) begin
        checks++;
        if (valid_o !== 1'b1 || m_to_w_bus[101:70] !== 32'hFFFF_FF80 ||
            forward_result_memory !== 32'hFFFF_FF80) begin
          errors++;
          $display("FAIL lb_result got v=%b ld=%h fwd=%h need 1 ffffff80",
                   valid_o, m_to_w_bus[101:70], forward_result_memory);
        end
      end
    end
    checks++;
    if (low != 4) begin
      errors++;
      $display("FAIL lb_allowin_low got %0d cycles need 4", low);
    end
  endtask

  task automatic test_lhu_sb();
    sb_q.push_back('{alu: 32'h2002, ld: 32'h0000_8001, chk_ld: 1'b1, dest: 5'd9, pc: 32'h104});
    issue(mk(1'b1, 1'b0, 2'd1, 1'b1, 32'h0, 32'h2002, 5'd9, 32'h104));
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      data_gnt = (i == 0);
      data_rvalid = (i == 1);
      data_rdata = 32'h8001_0000;
      #1;
      if (i == 1) begin
        checks++;
        if (valid_o !== 1'b1 || m_to_w_bus[101:70] !== 32'h0000_8001) begin
          errors++;
          $display("FAIL lhu_result got v=%b ld=%h need 1 00008001", valid_o, m_to_w_bus[101:70]);
        end
      end
    end
    sb_q.push_back('{alu: 32'h11, ld: 32'h0, chk_ld: 1'b0, dest: 5'd0, pc: 32'h108});
    issue(mk(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_00EF, 32'h11, 5'd0, 32'h108));
    data_gnt = 1'b1;
    #1;
    checks++;
    if (data_wstrb !== 4'b0010 || data_wdata !== 32'hEFEF_EFEF || data_wr !== 1'b1 ||
        data_req !== 1'b1) begin
      errors++;
      $display("FAIL sb_strobe got strb=%b wdata=%h wr=%b req=%b need 0010 efefefef 1 1",
               data_wstrb, data_wdata, data_wr, data_req);
    end
    checks++;
    if (valid_o !== 1'b1 || memory_allowin_o !== 1'b1) begin
      errors++;
      $display("FAIL sb_grant got v=%b allow=%b need 1 1", valid_o, memory_allowin_o);
    end
    @(negedge clk);
    data_gnt = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || data_req !== 1'b0) begin
      errors++;
      $display("FAIL sb_after got v=%b req=%b need 0 0", valid_o, data_req);
    end
  endtask

  task automatic test_flush_wait();
    issue(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h3000, 5'd3, 32'h10C));
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      data_gnt = (i == 0);
      flush_memory = (i == 1);
      data_rvalid = (i == 3);
      data_rdata = 32'hDEAD_BEEF;
      #1;
      if (i == 2) begin
        checks++;
        if (memory_allowin_o !== 1'b0 || data_req !== 1'b0 || valid_o !== 1'b0) begin
          errors++;
          $display("FAIL flush_drain got allow=%b req=%b v=%b need 0 0 0",
                   memory_allowin_o, data_req, valid_o);
        end
      end
      if (i == 4) begin
        checks++;
        if (memory_allowin_o !== 1'b1) begin
          errors++;
          $display("FAIL flush_drain_exit got allow=%b need 1", memory_allowin_o);
        end
      end
    end
    sb_q.push_back('{alu: 32'h3004, ld: 32'h1122_3344, chk_ld: 1'b1, dest: 5'd4, pc: 32'h110});
    issue(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h3004, 5'd4, 32'h110));
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      data_gnt = (i == 0);
      data_rvalid = (i == 1);
      data_rdata = 32'h1122_3344;
      #1;
      if (i == 1) begin
        checks++;
        if (valid_o !== 1'b1 || forward_result_memory !== 32'h1122_3344) begin
          errors++;
          $display("FAIL flush_next_load got v=%b fwd=%h need 1 11223344",
                   valid_o, forward_result_memory);
        end
      end
    end
  endtask

  task automatic test_flush_req();
    issue(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h4000, 5'd6, 32'h114));
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      flush_memory = (i == 1);
      #1;
      if (i == 1) begin
        checks++;
        if (data_req !== 1'b1 || valid_o !== 1'b0) begin
          errors++;
          $display("FAIL flush_req_hold got req=%b v=%b need 1 0", data_req, valid_o);
        end
      end
      if (i == 2) begin
        checks++;
        if (data_req !== 1'b0 || memory_allowin_o !== 1'b1 || valid_o !== 1'b0) begin
          errors++;
          $display("FAIL flush_req_drop got req=%b allow=%b v=%b need 0 1 0",
                   data_req, memory_allowin_o, valid_o);
        end
      end
    end
  endtask

  task automatic test_timeout_reset();
    issue(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h5000, 5'd8, 32'h118));
    data_gnt = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      data_gnt = 1'b0;
      #1;
      if (k == 8) begin
        checks++;
        if (mem_timeout_o !== 1'b0) begin
          errors++;
          $display("FAIL timeout_early got %b need 0 after 7 wait cycles", mem_timeout_o);
        end
      end
      if (k == 9) begin
        checks++;
        if (mem_timeout_o !== 1'b1) begin
          errors++;
          $display("FAIL timeout_set got %b need 1 after 8 wait cycles", mem_timeout_o);
        end
      end
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (valid_o !== 1'b0 || data_req !== 1'b0 || mem_timeout_o !== 1'b0 ||
        memory_allowin_o !== 1'b1 || m_to_h_bus !== 7'd0) begin
      errors++;
      $display("FAIL async_reset got v=%b req=%b to=%b allow=%b h=%b need 0 0 0 1 0",
               valid_o, data_req, mem_timeout_o, memory_allowin_o, m_to_h_bus);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_scoreboard_empty();
    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_missing got %0d outstanding results need 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb();
    test_lhu_sb();
    test_flush_wait();
    test_flush_req();
    test_timeout_reset();
    test_scoreboard_empty();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
